// File: rtl/btb_pkg.sv
// Shared types for the BTB write arbiter: the update record written into the BTB
// and the PC-to-update split helper.
package btb_pkg;

    localparam int INDEX_W = 6;
    localparam int TAG_W   = 32 - INDEX_W - 2;
    localparam int KEY_W   = INDEX_W + TAG_W;

    typedef struct packed {
        logic [INDEX_W-1:0] index;
        logic [TAG_W-1:0]   tag;
        logic [31:0]        target;
    } btb_upd_t;

    // pc[1:0] carry no information for word-aligned branches and are dropped.
    function automatic btb_upd_t pc2upd(input logic [31:0] pc, input logic [31:0] target);
        btb_upd_t u;
        u.index  = pc[INDEX_W+1:2];
        u.tag    = pc[31:INDEX_W+2];
        u.target = target;
        return u;
    endfunction

endpackage

// File: rtl/btb_wr_arbiter_if.sv
// Request side (EX/ID stages, hazard hold) and BTB write side of the arbiter.
interface btb_wr_arbiter_if #(
    parameter int INDEX_WIDTH = btb_pkg::INDEX_W,
    parameter int DEPTH       = 4
);
    localparam int TW    = 32 - INDEX_WIDTH - 2;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                   ex_req_i;
    logic [31:0]            ex_pc_i;
    logic [31:0]            ex_target_i;
    logic                   ex_ready_o;
    logic                   id_req_i;
    logic [31:0]            id_pc_i;
    logic [31:0]            id_target_i;
    logic                   id_ready_o;
    logic                   hold_i;
    logic                   btb_wren_o;
    logic [INDEX_WIDTH-1:0] btb_wr_index_o;
    logic [TW-1:0]          btb_wr_tag_o;
    logic [31:0]            btb_wr_target_o;
    logic [CNT_W-1:0]       count_o;

    modport master (
        output ex_req_i, ex_pc_i, ex_target_i, id_req_i, id_pc_i, id_target_i, hold_i,
        input  ex_ready_o, id_ready_o, btb_wren_o, btb_wr_index_o, btb_wr_tag_o,
               btb_wr_target_o, count_o
    );

    modport slave (
        input  ex_req_i, ex_pc_i, ex_target_i, id_req_i, id_pc_i, id_target_i, hold_i,
        output ex_ready_o, id_ready_o, btb_wren_o, btb_wr_index_o, btb_wr_tag_o,
               btb_wr_target_o, count_o
    );

endinterface

// File: rtl/btb_wr_fifo.sv
// Coalescing update FIFO: two ordered pushes, one pop, per-entry key match vectors
// and in-place target overwrite of matched entries.
module btb_wr_fifo
    import btb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push0,
    input  btb_upd_t         push0_data,
    input  logic             push1,
    input  btb_upd_t         push1_data,
    input  logic             pop,
    input  logic [KEY_W-1:0] key0,
    input  logic [KEY_W-1:0] key1,
    output logic [DEPTH-1:0] match0,
    output logic [DEPTH-1:0] match1,
    input  logic [DEPTH-1:0] upd0_sel,
    input  logic [31:0]      upd0_target,
    input  logic [DEPTH-1:0] upd1_sel,
    input  logic [31:0]      upd1_target,
    output btb_upd_t         head,
    output logic [DEPTH-1:0] head_sel,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    btb_upd_t         mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] wr1_ptr;

    // push1 lands behind push0 when both fire, otherwise it takes the tail slot.
    assign wr1_ptr = wr_ptr + PTR_W'(push0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PTR_W'(1);
            end
            if (push0) valid[wr_ptr]  <= 1'b1;
            if (push1) valid[wr1_ptr] <= 1'b1;
            wr_ptr <= wr_ptr + PTR_W'(push0) + PTR_W'(push1);
            count  <= count + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push0) mem[wr_ptr]  <= push0_data;
        if (push1) mem[wr1_ptr] <= push1_data;
        for (int i = 0; i < DEPTH; i++) begin
            if (upd0_sel[i]) mem[i].target <= upd0_target;
            if (upd1_sel[i]) mem[i].target <= upd1_target;
        end
    end

    always_comb begin
        match0   = '0;
        match1   = '0;
        head_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match0[i] = valid[i] && ({mem[i].index, mem[i].tag} == key0);
            match1[i] = valid[i] && ({mem[i].index, mem[i].tag} == key1);
        end
        head_sel[rd_ptr] = 1'b1;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/btb_wr_arbiter.sv
// Merges EX branch resolutions and ID JAL decodes into one BTB write port through
// a small coalescing FIFO; EX has fixed priority over ID.
module btb_wr_arbiter
    import btb_pkg::*;
#(
    parameter int INDEX_WIDTH = INDEX_W,
    parameter int DEPTH       = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    btb_wr_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    if (INDEX_WIDTH != INDEX_W) begin : g_width_check
        $error("btb_wr_arbiter: INDEX_WIDTH must equal btb_pkg::INDEX_W");
    end

    // Handshake: a request transfers in a cycle where req and ready are both high;
    // the requester holds req/pc/target stable until that cycle. Ready looks only at
    // the registered count, never at this cycle's pop or coalesce.
    btb_upd_t         ex_upd;
    btb_upd_t         id_upd;
    btb_upd_t         head;
    logic [KEY_W-1:0] ex_key;
    logic [KEY_W-1:0] id_key;
    logic [DEPTH-1:0] match0;
    logic [DEPTH-1:0] match1;
    logic [DEPTH-1:0] head_sel;
    logic [DEPTH-1:0] ex_live;
    logic [DEPTH-1:0] id_live;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             pop;
    logic             ex_ready;
    logic             id_ready;
    logic             ex_acc;
    logic             id_acc;
    logic             id_keep;
    logic             push0;
    logic             push1;

    assign ex_upd = pc2upd(bus.ex_pc_i, bus.ex_target_i);
    assign id_upd = pc2upd(bus.id_pc_i, bus.id_target_i);
    assign ex_key = {ex_upd.index, ex_upd.tag};
    assign id_key = {id_upd.index, id_upd.tag};

    assign ex_ready = count < CNT_W'(DEPTH);
    assign id_ready = bus.ex_req_i ? (count < CNT_W'(DEPTH - 1)) : (count < CNT_W'(DEPTH));
    assign pop      = !empty && !bus.hold_i;

    assign ex_acc = bus.ex_req_i && ex_ready;
    assign id_acc = bus.id_req_i && id_ready;

    // The head leaving this cycle cannot absorb a coalesce; the request gets a new slot.
    assign ex_live = match0 & ~({DEPTH{pop}} & head_sel);
    assign id_live = match1 & ~({DEPTH{pop}} & head_sel);

    assign push0   = ex_acc && !(|ex_live);
    assign id_keep = id_acc && !(ex_acc && (ex_key == id_key));
    assign push1   = id_keep && !(|id_live);

    btb_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk_i),
        .rst         (rst_i),
        .push0       (push0),
        .push0_data  (ex_upd),
        .push1       (push1),
        .push1_data  (id_upd),
        .pop         (pop),
        .key0        (ex_key),
        .key1        (id_key),
        .match0      (match0),
        .match1      (match1),
        .upd0_sel    (ex_acc ? ex_live : '0),
        .upd0_target (bus.ex_target_i),
        .upd1_sel    (id_keep ? id_live : '0),
        .upd1_target (bus.id_target_i),
        .head        (head),
        .head_sel    (head_sel),
        .empty       (empty),
        .count       (count)
    );

    assign bus.ex_ready_o      = ex_ready;
    assign bus.id_ready_o      = id_ready;
    assign bus.btb_wren_o      = pop;
    assign bus.btb_wr_index_o  = empty ? '0 : head.index;
    assign bus.btb_wr_tag_o    = empty ? '0 : head.tag;
    assign bus.btb_wr_target_o = empty ? '0 : head.target;
    assign bus.count_o         = count;

endmodule

// File: tb/tb_btb_wr_arbiter.sv
// Directed bench for btb_wr_arbiter: single write, dual enqueue, hold/full, coalesce,
// same-cycle collision and asynchronous reset mid-drain.
module tb_btb_wr_arbiter;

    localparam int W = 62;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [W-1:0] exp_q[$];

    btb_wr_arbiter_if #(.INDEX_WIDTH(6), .DEPTH(4)) bus ();

    btb_wr_arbiter #(.INDEX_WIDTH(6), .DEPTH(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // index = pc[7:2], tag = pc[31:8]
    function automatic logic [W-1:0] upd(input logic [31:0] pc, input logic [31:0] t);
        return {pc[7:2], pc[31:8], t};
    endfunction

    function automatic logic [W-1:0] wr_data();
        return {bus.btb_wr_index_o, bus.btb_wr_tag_o, bus.btb_wr_target_o};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic er, input logic [31:0] ep, input logic [31:0] et,
                       input logic ir, input logic [31:0] ip, input logic [31:0] it,
                       input logic h);
        @(negedge clk);
        bus.ex_req_i    = er;
        bus.ex_pc_i     = ep;
        bus.ex_target_i = et;
        bus.id_req_i    = ir;
        bus.id_pc_i     = ip;
        bus.id_target_i = it;
        bus.hold_i      = h;
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic expect_write(input string tag, input int cnt);
        logic [W-1:0] e;
        idle();
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        chk({tag, "_wren"}, 64'(bus.btb_wren_o), 64'd1);
        chk({tag, "_data"}, 64'(wr_data()), 64'(e));
        chk({tag, "_count"}, 64'(bus.count_o), 64'(cnt));
    endtask

    task automatic expect_empty(input string tag);
        idle();
        chk({tag, "_wren"}, 64'(bus.btb_wren_o), 64'd0);
        chk({tag, "_count"}, 64'(bus.count_o), 64'd0);
        chk({tag, "_data"}, 64'(wr_data()), 64'd0);
    endtask

    initial begin
        rst             = 1'b1;
        bus.ex_req_i    = 1'b0;
        bus.ex_pc_i     = '0;
        bus.ex_target_i = '0;
        bus.id_req_i    = 1'b0;
        bus.id_pc_i     = '0;
        bus.id_target_i = '0;
        bus.hold_i      = 1'b0;
        #2;
        chk("rst_count", 64'(bus.count_o), 64'd0);
        chk("rst_wren", 64'(bus.btb_wren_o), 64'd0);
        chk("rst_data", 64'(wr_data()), 64'd0);
        chk("rst_ex_ready", 64'(bus.ex_ready_o), 64'd1);
        chk("rst_id_ready", 64'(bus.id_ready_o), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single EX update: index 0x01, tag 0x000001, written the next cycle.
        cyc(1'b1, 32'h0000_0104, 32'h200, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("single_ex_ready", 64'(bus.ex_ready_o), 64'd1);
        chk("single_no_bypass", 64'(bus.btb_wren_o), 64'd0);
        exp_q.push_back({6'h01, 24'h000001, 32'h0000_0200});
        expect_write("single", 1);
        expect_empty("single_after");

        // EX and ID together on an empty FIFO: EX drains first.
        cyc(1'b1, 32'h100, 32'h300, 1'b1, 32'h180, 32'h500, 1'b0);
        chk("dual_ex_ready", 64'(bus.ex_ready_o), 64'd1);
        chk("dual_id_ready", 64'(bus.id_ready_o), 64'd1);
        exp_q.push_back(upd(32'h100, 32'h300));
        exp_q.push_back(upd(32'h180, 32'h500));
        expect_write("dual_first", 2);
        expect_write("dual_second", 1);
        expect_empty("dual_after");

        // Six held cycles: fill to full, ID blocked at count 3, both blocked at 4.
        cyc(1'b1, 32'h1000, 32'h10, 1'b0, 32'h0, 32'h0, 1'b1);
        exp_q.push_back(upd(32'h1000, 32'h10));
        cyc(1'b1, 32'h1004, 32'h11, 1'b1, 32'h2008, 32'h21, 1'b1);
        chk("hold_c1_count", 64'(bus.count_o), 64'd1);
        chk("hold_c1_id_ready", 64'(bus.id_ready_o), 64'd1);
        exp_q.push_back(upd(32'h1004, 32'h11));
        exp_q.push_back(upd(32'h2008, 32'h21));
        cyc(1'b1, 32'h100C, 32'h12, 1'b1, 32'h3010, 32'h22, 1'b1);
        chk("hold_c3_count", 64'(bus.count_o), 64'd3);
        chk("hold_c3_ex_ready", 64'(bus.ex_ready_o), 64'd1);
        chk("hold_c3_id_ready", 64'(bus.id_ready_o), 64'd0);
        chk("hold_c3_wren", 64'(bus.btb_wren_o), 64'd0);
        exp_q.push_back(upd(32'h100C, 32'h12));
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 32'h1010, 32'h13, 1'b1, 32'h3010, 32'h22, 1'b1);
            chk("hold_full_count", 64'(bus.count_o), 64'd4);
            chk("hold_full_ex_ready", 64'(bus.ex_ready_o), 64'd0);
            chk("hold_full_id_ready", 64'(bus.id_ready_o), 64'd0);
            chk("hold_full_wren", 64'(bus.btb_wren_o), 64'd0);
        end
        // Release: the popping cycle still reports not-ready since pops are not credited.
        idle();
        chk("release_ex_ready", 64'(bus.ex_ready_o), 64'd0);
        chk("release_wren", 64'(bus.btb_wren_o), 64'd1);
        chk("release_data", 64'(wr_data()), 64'(exp_q.pop_front()));
        expect_write("drain_1", 3);
        expect_write("drain_2", 2);
        expect_write("drain_3", 1);
        expect_empty("drain_after");

        // Coalesce under hold: second target overwrites the queued entry.
        cyc(1'b1, 32'h100, 32'h400, 1'b0, 32'h0, 32'h0, 1'b1);
        cyc(1'b1, 32'h100, 32'h800, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("coal_ex_ready", 64'(bus.ex_ready_o), 64'd1);
        exp_q.push_back(upd(32'h100, 32'h800));
        expect_write("coal", 1);
        expect_empty("coal_after");

        // Matching the popping head does not coalesce: old target leaves, new is queued.
        cyc(1'b1, 32'h100, 32'h400, 1'b0, 32'h0, 32'h0, 1'b1);
        cyc(1'b1, 32'h100, 32'hC00, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("headpop_wren", 64'(bus.btb_wren_o), 64'd1);
        chk("headpop_data", 64'(wr_data()), 64'(upd(32'h100, 32'h400)));
        exp_q.push_back(upd(32'h100, 32'hC00));
        expect_write("headpop_new", 1);
        expect_empty("headpop_after");

        // Same-cycle EX/ID collision: EX wins, ID is dropped but sees ready.
        cyc(1'b1, 32'h240, 32'hA00, 1'b1, 32'h240, 32'hB00, 1'b0);
        chk("coll_ex_ready", 64'(bus.ex_ready_o), 64'd1);
        chk("coll_id_ready", 64'(bus.id_ready_o), 64'd1);
        exp_q.push_back({6'h10, 24'h000002, 32'h0000_0A00});
        expect_write("coll", 1);
        expect_empty("coll_after");

        // Async reset with three queued entries while draining.
        cyc(1'b1, 32'h500, 32'h1, 1'b1, 32'h504, 32'h2, 1'b1);
        cyc(1'b1, 32'h508, 32'h3, 1'b0, 32'h0, 32'h0, 1'b1);
        idle();
        chk("pre_rst_count", 64'(bus.count_o), 64'd3);
        chk("pre_rst_wren", 64'(bus.btb_wren_o), 64'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_count", 64'(bus.count_o), 64'd0);
        chk("async_rst_wren", 64'(bus.btb_wren_o), 64'd0);
        chk("async_rst_data", 64'(wr_data()), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 3; i++) expect_empty("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
